// File: rtl/core_pkg.sv
// core_pkg: shared types for the MEM-stage bus controller
package core_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_e;
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [XLEN/8-1:0] wstrb;
    } bus_req_t;
endpackage

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: stalls the pipeline while a MEM-stage load/store runs on a valid/ready bus
module mem_stall_ctrl
    import core_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              mem_fault,
    output logic              stall_pipl,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [XLEN-1:0]   bus_req_addr,
    output logic [XLEN-1:0]   bus_req_wdata,
    output logic [XLEN/8-1:0] bus_req_wstrb,
    input  logic              bus_rsp_valid,
    input  logic [XLEN-1:0]   bus_rsp_rdata,
    input  logic              bus_rsp_err
);
    localparam int CW = $clog2(TIMEOUT);
    mem_state_e      state, state_nxt;
    bus_req_t        req;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rdata_nxt;
    logic            fault_nxt, access, expired;
    assign access  = mem_read | mem_write;
    assign expired = cnt == CW'(TIMEOUT - 1);
    always_comb begin
        state_nxt = state;
        rdata_nxt = '0;
        fault_nxt = 1'b0;
        unique case (state)
            IDLE: state_nxt = access ? REQ : IDLE;
            REQ: begin
                if (expired) begin
                    state_nxt = DONE;
                    fault_nxt = 1'b1;
                end else if (bus_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (expired) begin
                    state_nxt = DONE;
                    fault_nxt = 1'b1;
                end else if (bus_rsp_valid) begin
                    state_nxt = DONE;
                    fault_nxt = bus_rsp_err;
                    rdata_nxt = (bus_rsp_err | req.we) ? '0 : bus_rsp_rdata;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req       <= '0;
            cnt       <= '0;
            mem_rdata <= '0;
            mem_fault <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state == IDLE) ? '0 : cnt + 1'b1;
            mem_rdata <= rdata_nxt;
            mem_fault <= fault_nxt;
            if (state == IDLE && access)
                req <= '{we: mem_write, addr: mem_addr, wdata: mem_wdata,
                         wstrb: mem_write ? mem_wstrb : '0};
        end
    end
    // valid drops in the expiring cycle so no late handshake can race the timeout
    assign bus_req_valid = (state == REQ) && !expired;
    assign stall_pipl    = reset_n && ((state == IDLE && access) || state == REQ || state == WAIT);
    assign bus_req_we    = req.we;
    assign bus_req_addr  = req.addr;
    assign bus_req_wdata = req.wdata;
    assign bus_req_wstrb = req.wstrb;
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: directed and randomized transactions against a latency/outcome model
module tb_mem_stall_ctrl;
    localparam int T = 8;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb, bus_req_wstrb;
    logic        mem_fault, stall_pipl, bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;
    logic        bus_rsp_valid, bus_rsp_err;
    int          errors = 0;
    int          checks = 0;

    mem_stall_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_fault(mem_fault), .stall_pipl(stall_pipl),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One load/store: bus accepts d cycles after the request appears, responds r cycles after
    // acceptance. Outcome is derived from the cycle budget: T cycles in REQ+WAIT at most.
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input int d, input int r,
                       input logic [31:0] rd, input logic er, input bit b2b);
        bit          resp;
        int          st, last;
        logic [31:0] erd;
        logic        ef;
        resp = (d <= T - 2) && (d + 1 + r <= T - 2);
        st   = resp ? d + r + 3 : T + 1;
        ef   = resp ? er : 1'b1;
        erd  = (resp && !er && !we) ? rd : 32'h0;
        last = st + (b2b ? 0 : 1);
        if (d + r + 2 > last) last = d + r + 2;
        for (int k = 0; k <= last; k++) begin
            mem_write     = (k <= st) && we;
            mem_read      = (k <= st) && (!we || $urandom_range(0, 1) == 1);
            mem_addr      = (k == 0) ? a : $urandom;
            mem_wdata     = (k == 0) ? wd : $urandom;
            mem_wstrb     = (k == 0) ? ws : 4'($urandom);
            bus_req_ready = (k == d + 1);
            bus_rsp_valid = (k == d + r + 2);
            bus_rsp_rdata = (k == d + r + 2) ? rd : $urandom;
            bus_rsp_err   = (k == d + r + 2) ? er : 1'($urandom_range(0, 1));
            #1;
            chk("stall", stall_pipl, 32'(k < st));
            if (k >= 1 && k - 1 <= d && k - 1 <= T - 2) begin
                chk("req_valid", bus_req_valid, 1);
                chk("req_we", bus_req_we, we);
                chk("req_addr", bus_req_addr, a);
                if (we) chk("req_wdata", bus_req_wdata, wd);
            end else begin
                chk("req_idle", bus_req_valid, 0);
            end
            if (k >= 1) chk("req_wstrb", bus_req_wstrb, we ? ws : 4'h0);
            chk("rdata", mem_rdata, (k == st) ? erd : 32'h0);
            chk("fault", mem_fault, (k == st) ? ef : 1'b0);
            @(negedge clk);
        end
        mem_read = 0; mem_write = 0; bus_req_ready = 0; bus_rsp_valid = 0;
    endtask

    // Response with no transaction outstanding must not disturb anything
    task automatic stray_rsp();
        bus_rsp_valid = 1; bus_rsp_rdata = $urandom; bus_rsp_err = 1'($urandom_range(0, 1));
        #1;
        chk("stray_stall", stall_pipl, 0);
        @(negedge clk);
        bus_rsp_valid = 0;
        #1;
        chk("stray_fault", mem_fault, 0);
        chk("stray_rdata", mem_rdata, 0);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 0; mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0; bus_rsp_err = 0;
        repeat (2) @(negedge clk);
        mem_read = 1;
        #1;
        chk("rst_stall", stall_pipl, 0);
        chk("rst_valid", bus_req_valid, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_fault", mem_fault, 0);
        chk("rst_addr", bus_req_addr, 0);
        chk("rst_wstrb", bus_req_wstrb, 0);
        mem_read = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        txn(0, 32'h100, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF, 0, 0);
        txn(1, 32'h204, 32'hCAFE1234, 4'h3, 4, 0, 32'h11111111, 0, 0);
        txn(0, 32'h300, 32'h0, 4'hF, 1, 1, 32'h55AA55AA, 1, 0);
        txn(0, 32'h400, 32'h0, 4'h0, 20, 0, 32'h77777777, 0, 0);
        txn(0, 32'h500, 32'h0, 4'h0, 0, 0, 32'hA5A5A5A5, 0, 1);
        txn(0, 32'h504, 32'h0, 4'h0, 0, 0, 32'h5A5A5A5A, 0, 0);
        stray_rsp();
        // Reset while the response is pending
        mem_read = 1; mem_addr = 32'h600;
        @(negedge clk);
        bus_req_ready = 1;
        @(negedge clk);
        bus_req_ready = 0;
        #1;
        chk("wait_stall", stall_pipl, 1);
        reset_n = 0;
        #1;
        chk("rstw_stall", stall_pipl, 0);
        chk("rstw_valid", bus_req_valid, 0);
        @(negedge clk);
        reset_n = 1; mem_read = 0;
        stray_rsp();
        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 6)), $urandom,
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            if (i % 8 == 7) stray_rsp();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
